// File: rtl/jtframe_romrq.sv
// jtframe_romrq: one ROM client slot in front of the SDRAM arbiter.
// It turns a client address into an SDRAM word address and caches the last
// fetched 32-bit word (two words when DOUBLE=1). A request is raised only on
// a cache miss. The returned data can be combinational or registered.
module jtframe_romrq #(
  parameter int SDRAMW  = 22,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LATCH   = 0,
  parameter int DOUBLE  = 0,
  parameter int OKLATCH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [SDRAMW-1:0] offset,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  output logic [SDRAMW-1:0] sdram_addr,
  input  logic [15:0]       din,
  input  logic              din_ok,
  input  logic              dst,
  input  logic              we,
  output logic              req,
  output logic [DW-1:0]     dout,
  output logic              data_ok
);

  localparam int NE = (DOUBLE != 0) ? 2 : 1;

  // Cache storage. Entry 0 always holds the newest fill. Entry 1 holds the
  // fill before that.
  logic [NE-1:0]             valid;
  logic [NE-1:0][SDRAMW-1:0] tag;
  logic [NE-1:0][31:0]       data;
  logic [NE-1:0]             hit_e;

  logic [SDRAMW-1:0] addr_req;
  logic              hit, hit1;
  logic              fill, lo_we;
  logic [31:0]       fill_data;
  logic [31:0]       word;
  logic [DW-1:0]     dout_c;

  // Client address to SDRAM word address. Byte clients share a 16-bit
  // word. 32-bit clients always start on an even word.
  generate
    if (DW == 8) begin : g_areq8
      assign addr_req = SDRAMW'(addr >> 1);
    end else if (DW == 16) begin : g_areq16
      assign addr_req = SDRAMW'(addr);
    end else begin : g_areq32
      assign addr_req = SDRAMW'(addr) & {{(SDRAMW-1){1'b1}}, 1'b0};
    end
  endgenerate

  // The addition wraps within SDRAMW bits, so a slot can straddle the top of memory.
  assign sdram_addr = addr_req + offset;

  // A fill completes on the last beat. 32-bit clients take the low half
  // earlier, on the first beat.
  assign fill = we & din_ok;

  generate
    if (DW == 32) begin : g_fill32
      assign lo_we     = we & dst;
      assign fill_data = {din, data[0][15:0]};
    end else begin : g_fill16
      logic unused_dst;
      assign unused_dst = dst;
      assign lo_we      = 1'b0;
      assign fill_data  = {data[0][31:16], din};
    end
  endgenerate

  // Cache update. clr overrides a fill that completes in the same cycle.
  // Older entries shift down by one on every completed fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= '0;
    end else begin
      if (lo_we) data[0][15:0] <= din;
      if (fill) begin
        valid[0] <= 1'b1;
        tag[0]   <= addr_req;
        data[0]  <= fill_data;
        for (int i = 1; i < NE; i++) begin
          valid[i] <= valid[i-1];
          tag[i]   <= tag[i-1];
          data[i]  <= data[i-1];
        end
      end
    end
  end

  // Compare the tag of each entry with the current address.
  always_comb begin
    hit_e = '0;
    for (int i = 0; i < NE; i++)
      hit_e[i] = valid[i] && (tag[i] == addr_req);
  end

  assign hit1 = (NE > 1) && hit_e[NE-1];
  assign hit  = hit_e[0] | hit1;
  assign req  = addr_ok & ~hit & ~we;
  assign word = hit1 ? data[NE-1] : data[0];

  // Pick the client-sized part of the cached word.
  generate
    if (DW == 8) begin : g_sel8
      logic unused_word;
      assign unused_word = ^word[31:16];
      assign dout_c = addr[0] ? word[15:8] : word[7:0];
    end else if (DW == 16) begin : g_sel16
      logic unused_word;
      assign unused_word = ^word[31:16];
      assign dout_c = word[15:0];
    end else begin : g_sel32
      assign dout_c = word;
    end
  endgenerate

  generate
    if (LATCH != 0) begin : g_dlatch
      logic [DW-1:0] dout_r;
      // Registered data adds one cycle of latency and gives a clean path to the client.
      always_ff @(posedge clk) begin
        if (!rst) dout_r <= '0;
        else      dout_r <= dout_c;
      end
      assign dout = dout_r;
    end else begin : g_dcomb
      assign dout = dout_c;
    end
  endgenerate

  generate
    if (OKLATCH != 0) begin : g_oklatch
      logic ok_r;
      // Registered data_ok. It lines up with registered dout when both are latched.
      always_ff @(posedge clk) begin
        if (!rst) ok_r <= 1'b0;
        else      ok_r <= addr_ok & hit;
      end
      assign data_ok = ok_r;
    end else begin : g_okcomb
      assign data_ok = addr_ok & hit;
    end
  endgenerate

endmodule

// File: tb/tb_jtframe_romrq.sv
// Testbench for jtframe_romrq. It builds three configurations:
// u8: byte client, latched dout and data_ok.
// u32: 32-bit client, fully combinational outputs.
// ud: 16-bit client with two cache entries.
module tb_jtframe_romrq;
  localparam int SW = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // byte client, LATCH=1 OKLATCH=1
  logic          clr8 = 0, ok8 = 0, dok8 = 0, dst8 = 0, we8 = 0;
  logic [SW-1:0] off8 = '0;
  logic [7:0]    a8 = '0;
  logic [15:0]   din8 = '0;
  logic [SW-1:0] sd8;
  logic          req8, v8;
  logic [7:0]    dout8;

  // 32-bit client, LATCH=0 OKLATCH=0
  logic          clr32 = 0, ok32 = 0, dok32 = 0, dst32 = 0, we32 = 0;
  logic [SW-1:0] off32 = '0;
  logic [7:0]    a32 = '0;
  logic [15:0]   din32 = '0;
  logic [SW-1:0] sd32;
  logic          req32, v32;
  logic [31:0]   dout32;

  // 16-bit client, DOUBLE=1, LATCH=0 OKLATCH=1
  logic          clrd = 0, okd = 0, dokd = 0, dstd = 0, wed = 0;
  logic [SW-1:0] offd = '0;
  logic [7:0]    ad = '0;
  logic [15:0]   dind = '0;
  logic [SW-1:0] sdd;
  logic          reqd, vd;
  logic [15:0]   doutd;

  jtframe_romrq #(.SDRAMW(SW), .AW(8), .DW(8), .LATCH(1), .DOUBLE(0), .OKLATCH(1)) u8 (
    .clk(clk), .rst(rst), .clr(clr8), .offset(off8), .addr(a8), .addr_ok(ok8),
    .sdram_addr(sd8), .din(din8), .din_ok(dok8), .dst(dst8), .we(we8),
    .req(req8), .dout(dout8), .data_ok(v8));

  jtframe_romrq #(.SDRAMW(SW), .AW(8), .DW(32), .LATCH(0), .DOUBLE(0), .OKLATCH(0)) u32 (
    .clk(clk), .rst(rst), .clr(clr32), .offset(off32), .addr(a32), .addr_ok(ok32),
    .sdram_addr(sd32), .din(din32), .din_ok(dok32), .dst(dst32), .we(we32),
    .req(req32), .dout(dout32), .data_ok(v32));

  jtframe_romrq #(.SDRAMW(SW), .AW(8), .DW(16), .LATCH(0), .DOUBLE(1), .OKLATCH(1)) ud (
    .clk(clk), .rst(rst), .clr(clrd), .offset(offd), .addr(ad), .addr_ok(okd),
    .sdram_addr(sdd), .din(dind), .din_ok(dokd), .dst(dstd), .we(wed),
    .req(reqd), .dout(doutd), .data_ok(vd));

  task automatic test_reset;
    rst = 0; ok8 = 1; a8 = 8'h05; off8 = 22'h100;
    ok32 = 1; a32 = 8'h03; off32 = 22'h40; okd = 1; ad = 8'h07;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (req8 !== 1'b1) begin bad++; $display("FAIL reset_req8 got=%b exp=1", req8); end
    total++; if (v8 !== 1'b0) begin bad++; $display("FAIL reset_ok8 got=%b exp=0", v8); end
    total++; if (dout8 !== 8'h00) begin bad++; $display("FAIL reset_dout8 got=%h exp=00", dout8); end
    total++; if (sd8 !== 22'h102) begin bad++; $display("FAIL reset_sd8 got=%h exp=102", sd8); end
    total++; if (v32 !== 1'b0) begin bad++; $display("FAIL reset_ok32 got=%b exp=0", v32); end
    total++; if (vd !== 1'b0 || reqd !== 1'b1) begin bad++; $display("FAIL reset_d got=%b%b exp=01", vd, reqd); end
    rst = 1;
  endtask

  task automatic test_fill8;
    @(negedge clk); off8 = 22'h100; a8 = 8'h05; ok8 = 1; #1;
    total++; if (sd8 !== 22'h102) begin bad++; $display("FAIL f8_sd got=%h exp=102", sd8); end
    total++; if (req8 !== 1'b1) begin bad++; $display("FAIL f8_req got=%b exp=1", req8); end
    @(negedge clk); we8 = 1; dok8 = 1; din8 = 16'hABCD; #1;
    total++; if (req8 !== 1'b0) begin bad++; $display("FAIL f8_we_gate got=%b exp=0", req8); end
    @(negedge clk); we8 = 0; dok8 = 0; #1;
    total++; if (req8 !== 1'b0) begin bad++; $display("FAIL f8_hit_req got=%b exp=0", req8); end
    total++; if (v8 !== 1'b0) begin bad++; $display("FAIL f8_ok_early got=%b exp=0", v8); end
    @(negedge clk); #1;
    total++; if (v8 !== 1'b1 || dout8 !== 8'hAB) begin bad++; $display("FAIL f8_data got=%b/%h exp=1/ab", v8, dout8); end
    @(negedge clk); a8 = 8'h04; #1;
    total++; if (req8 !== 1'b0) begin bad++; $display("FAIL f8_even_req got=%b exp=0", req8); end
    @(negedge clk); #1;
    total++; if (v8 !== 1'b1 || dout8 !== 8'hCD) begin bad++; $display("FAIL f8_even got=%b/%h exp=1/cd", v8, dout8); end
  endtask

  task automatic test_ignore;
    @(negedge clk); a8 = 8'h20; dok8 = 1; dst8 = 1; din8 = 16'h5555; #1;
    total++; if (req8 !== 1'b1) begin bad++; $display("FAIL ign_req0 got=%b exp=1", req8); end
    @(negedge clk); dok8 = 0; dst8 = 0; #1;
    total++; if (req8 !== 1'b1) begin bad++; $display("FAIL ign_req1 got=%b exp=1", req8); end
  endtask

  task automatic test_clr;
    @(negedge clk); a8 = 8'h05; #1;
    total++; if (req8 !== 1'b0) begin bad++; $display("FAIL clr_pre got=%b exp=0", req8); end
    @(negedge clk); clr8 = 1;
    @(negedge clk); clr8 = 0; #1;
    total++; if (req8 !== 1'b1) begin bad++; $display("FAIL clr_req got=%b exp=1", req8); end
    @(negedge clk); #1;
    total++; if (v8 !== 1'b0) begin bad++; $display("FAIL clr_ok got=%b exp=0", v8); end
    @(negedge clk); we8 = 1; dok8 = 1; din8 = 16'h1234; clr8 = 1;
    @(negedge clk); we8 = 0; dok8 = 0; clr8 = 0; #1;
    total++; if (req8 !== 1'b1) begin bad++; $display("FAIL clr_wins got=%b exp=1", req8); end
  endtask

  task automatic test_wrap;
    @(negedge clk); off8 = 22'h3FFFFF; a8 = 8'h04; #1;
    total++; if (sd8 !== 22'h000001) begin bad++; $display("FAIL wrap1 got=%h exp=000001", sd8); end
    @(negedge clk); a8 = 8'h01; #1;
    total++; if (sd8 !== 22'h3FFFFF) begin bad++; $display("FAIL wrap0 got=%h exp=3fffff", sd8); end
  endtask

  task automatic test_dw32;
    @(negedge clk); off32 = 22'h40; a32 = 8'h03; ok32 = 1; #1;
    total++; if (sd32 !== 22'h42 || req32 !== 1'b1) begin bad++; $display("FAIL d32_addr got=%h/%b exp=42/1", sd32, req32); end
    @(negedge clk); we32 = 1; dst32 = 1; din32 = 16'h1111; #1;
    total++; if (v32 !== 1'b0 || req32 !== 1'b0) begin bad++; $display("FAIL d32_beat0 got=%b/%b exp=0/0", v32, req32); end
    @(negedge clk); dst32 = 0; dok32 = 1; din32 = 16'h2222; #1;
    total++; if (v32 !== 1'b0) begin bad++; $display("FAIL d32_beat1 got=%b exp=0", v32); end
    @(negedge clk); we32 = 0; dok32 = 0; #1;
    total++; if (v32 !== 1'b1 || dout32 !== 32'h22221111 || req32 !== 1'b0) begin
      bad++; $display("FAIL d32_data got=%b/%h/%b exp=1/22221111/0", v32, dout32, req32); end
    @(negedge clk); a32 = 8'h02; #1;
    total++; if (req32 !== 1'b0 || dout32 !== 32'h22221111) begin bad++; $display("FAIL d32_even got=%b/%h exp=0/22221111", req32, dout32); end
  endtask

  task automatic test_rst_midfill;
    @(negedge clk); a32 = 8'h10; #1;
    total++; if (req32 !== 1'b1) begin bad++; $display("FAIL mid_req got=%b exp=1", req32); end
    @(negedge clk); we32 = 1; dst32 = 1; din32 = 16'h9999;
    @(negedge clk); dst32 = 0; we32 = 0; rst = 0;
    @(negedge clk); rst = 1; #1;
    total++; if (req32 !== 1'b1) begin bad++; $display("FAIL mid_after got=%b exp=1", req32); end
    @(negedge clk); we32 = 1; dok32 = 1; din32 = 16'h3333;
    @(negedge clk); we32 = 0; dok32 = 0; #1;
    total++; if (v32 !== 1'b1 || dout32 !== 32'h33330000) begin bad++; $display("FAIL mid_data got=%b/%h exp=1/33330000", v32, dout32); end
  endtask

  task automatic filld(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); ad = a; okd = 1; #1;
    total++; if (reqd !== 1'b1) begin bad++; $display("FAIL dbl_miss_%h got=%b exp=1", a, reqd); end
    @(negedge clk); wed = 1; dokd = 1; dind = d;
    @(negedge clk); wed = 0; dokd = 0; #1;
    total++; if (reqd !== 1'b0 || doutd !== d) begin bad++; $display("FAIL dbl_fill_%h got=%b/%h exp=0/%h", a, reqd, doutd, d); end
  endtask

  task automatic test_double;
    offd = '0;
    filld(8'h11, 16'hAAAA);
    filld(8'h22, 16'hBBBB);
    @(negedge clk); ad = 8'h11; #1;
    total++; if (reqd !== 1'b0 || doutd !== 16'hAAAA) begin bad++; $display("FAIL dbl_A got=%b/%h exp=0/aaaa", reqd, doutd); end
    @(negedge clk); #1;
    total++; if (vd !== 1'b1) begin bad++; $display("FAIL dbl_A_ok got=%b exp=1", vd); end
    @(negedge clk); ad = 8'h22; #1;
    total++; if (reqd !== 1'b0 || doutd !== 16'hBBBB) begin bad++; $display("FAIL dbl_B got=%b/%h exp=0/bbbb", reqd, doutd); end
    filld(8'h33, 16'hCCCC);
    @(negedge clk); ad = 8'h11; #1;
    total++; if (reqd !== 1'b1) begin bad++; $display("FAIL dbl_A_evict got=%b exp=1", reqd); end
    @(negedge clk); ad = 8'h22; #1;
    total++; if (reqd !== 1'b0 || doutd !== 16'hBBBB) begin bad++; $display("FAIL dbl_B_kept got=%b/%h exp=0/bbbb", reqd, doutd); end
  endtask

  // Random traffic on the two-entry slot. The reference model is a list of
  // the most recent fills, newest first and at most two long. A lookup that
  // matches both entries returns the older one.
  task automatic test_random;
    logic [SW-1:0] mtag[$];
    logic [15:0]   mdat[$];
    logic          prev_ok;
    logic          mhit;
    logic [15:0]   mword;
    logic [SW-1:0] areq, exp_sd;
    logic          exp_req;
    @(negedge clk); rst = 0; clrd = 0; wed = 0; dokd = 0; dstd = 0;
    @(negedge clk); rst = 1;
    prev_ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 79) != 0);
      clrd = ($urandom_range(0, 29) == 0);
      ad   = 8'($urandom_range(0, 5));
      okd  = ($urandom_range(0, 4) != 0);
      wed  = ($urandom_range(0, 2) == 0);
      dokd = wed ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      dstd = ($urandom_range(0, 3) == 0);
      dind = 16'($urandom);
      if ($urandom_range(0, 15) == 0) offd = 22'($urandom);
      #1;
      areq = {14'd0, ad};
      mhit = 1'b0; mword = '0;
      for (int k = 0; k < mtag.size(); k++)
        if (mtag[k] == areq) begin mhit = 1'b1; mword = mdat[k]; end
      exp_req = okd && !mhit && !wed;
      exp_sd  = areq + offd;
      total++; if (reqd !== exp_req) begin bad++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, reqd, exp_req); end
      total++; if (sdd !== exp_sd) begin bad++; $display("FAIL rnd_sd i=%0d got=%h exp=%h", i, sdd, exp_sd); end
      total++; if (vd !== prev_ok) begin bad++; $display("FAIL rnd_ok i=%0d got=%b exp=%b", i, vd, prev_ok); end
      if (mhit) begin
        total++; if (doutd !== mword) begin bad++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, doutd, mword); end
      end
      if (!rst) begin
        mtag.delete(); mdat.delete(); prev_ok = 1'b0;
      end else begin
        prev_ok = okd && mhit;
        if (clrd) begin
          mtag.delete(); mdat.delete();
        end else if (wed && dokd) begin
          mtag.push_front(areq); mdat.push_front(dind);
          if (mtag.size() > 2) begin void'(mtag.pop_back()); void'(mdat.pop_back()); end
        end
      end
    end
    @(negedge clk); rst = 1; clrd = 0; wed = 0; dokd = 0; dstd = 0;
  endtask

  initial begin
    test_reset;
    test_fill8;
    test_ignore;
    test_clr;
    test_wrap;
    test_dw32;
    test_rst_midfill;
    test_double;
    test_random;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
